// File: rtl/lane_mux_rr.sv
// Round-robin multiplexer: per-lane FIFOs drained into one registered output,
// either in fixed TDM slots or skipping idle lanes.
module lane_mux_rr #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  localparam int LW       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset_L,
  input  logic [NUM_LANES*DATA_W-1:0] data_in,
  input  logic [NUM_LANES-1:0]        valid_in,
  input  logic                        mode_skip,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           data_out,
  output logic                        valid_out,
  output logic [LW-1:0]               lane_out,
  output logic [NUM_LANES-1:0]        full_out,
  output logic [NUM_LANES-1:0]        overflow_err
);

  logic [NUM_LANES-1:0] empty_w;
  logic [NUM_LANES-1:0] full_w;
  logic [NUM_LANES-1:0] push_w;
  logic [NUM_LANES-1:0] pop_w;
  logic [DATA_W-1:0]    head_w [NUM_LANES];

  logic              loadable_w;
  logic              hit_w;
  logic [LW-1:0]     sel_w;
  logic [LW-1:0]     cand_w;
  int                idx_w;

  logic [DATA_W-1:0] data_reg, data_next;
  logic              valid_reg, valid_next;
  logic [LW-1:0]     lane_reg, lane_next;
  logic [LW-1:0]     ptr_reg, ptr_next;

  function automatic logic [LW-1:0] wrap_inc(input logic [LW-1:0] p);
    return (p == LW'(NUM_LANES - 1)) ? '0 : p + LW'(1);
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [DATA_W-1:0] mem_reg [DEPTH];
      logic [AW-1:0]     wr_ptr_reg;
      logic [AW-1:0]     rd_ptr_reg;
      logic [AW:0]       count_reg;
      logic              ovf_reg;

      assign empty_w[gi]      = (count_reg == '0);
      assign full_w[gi]       = (count_reg == (AW+1)'(DEPTH));
      // Full is judged on the pre-edge count, so a same-cycle pop never makes room.
      assign push_w[gi]       = valid_in[gi] & ~full_w[gi];
      assign pop_w[gi]        = loadable_w & hit_w & (sel_w == LW'(gi));
      assign head_w[gi]       = mem_reg[rd_ptr_reg];
      assign full_out[gi]     = full_w[gi];
      assign overflow_err[gi] = ovf_reg;

      always_ff @(posedge clk) begin
        if (push_w[gi]) begin
          mem_reg[wr_ptr_reg] <= data_in[gi*DATA_W +: DATA_W];
        end
      end

      always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
          ovf_reg    <= 1'b0;
        end else begin
          if (push_w[gi]) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
          end
          if (pop_w[gi]) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
          end
          if (push_w[gi] && !pop_w[gi]) begin
            count_reg <= count_reg + (AW+1)'(1);
          end else if (!push_w[gi] && pop_w[gi]) begin
            count_reg <= count_reg - (AW+1)'(1);
          end
          if (valid_in[gi] && full_w[gi]) begin
            ovf_reg <= 1'b1;
          end
        end
      end
    end
  endgenerate

  // Lane selection: fixed slot at ptr, or first non-empty lane from ptr onward.
  always_comb begin
    loadable_w = !valid_reg || out_ready;
    hit_w      = 1'b0;
    sel_w      = ptr_reg;
    idx_w      = 0;
    cand_w     = '0;
    if (!mode_skip) begin
      hit_w = !empty_w[ptr_reg];
    end else begin
      for (int j = 0; j < NUM_LANES; j++) begin
        idx_w = int'(ptr_reg) + j;
        if (idx_w >= NUM_LANES) begin
          idx_w = idx_w - NUM_LANES;
        end
        cand_w = LW'(idx_w);
        if (!hit_w && !empty_w[cand_w]) begin
          hit_w = 1'b1;
          sel_w = cand_w;
        end
      end
    end
  end

  always_comb begin
    data_next  = data_reg;
    valid_next = valid_reg;
    lane_next  = lane_reg;
    ptr_next   = ptr_reg;
    if (loadable_w) begin
      valid_next = hit_w;
      data_next  = hit_w ? head_w[sel_w] : '0;
      if (!mode_skip) begin
        lane_next = ptr_reg;
        ptr_next  = wrap_inc(ptr_reg);
      end else if (hit_w) begin
        lane_next = sel_w;
        ptr_next  = wrap_inc(sel_w);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
      lane_reg  <= '0;
      ptr_reg   <= '0;
    end else begin
      data_reg  <= data_next;
      valid_reg <= valid_next;
      lane_reg  <= lane_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign data_out  = data_reg;
  assign valid_out = valid_reg;
  assign lane_out  = lane_reg;

endmodule
